// File: rtl/tos_dec_pkg.sv
// ---------------------------------------------------------------------------
// tos_dec_pkg
// Shared types for the top-of-second count decoder:
//   tos_state_e  - window FSM state (S_idle / S_count)
//   tos_result_t - one window measurement (count, timeout, overflow, phase)
// The result fields are sized for the widest supported configuration; the
// decoder uses the low CW / PW bits and keeps the rest at zero.
// Optional feature macro used by the decoder: TOS_DEC_PHASE_EN.
// ---------------------------------------------------------------------------
package tos_dec_pkg;

   localparam int unsigned RES_CNT_W = 32'd32;
   localparam int unsigned RES_PH_W  = 32'd32;

   typedef enum logic [0:0] {
      S_idle  = 1'b0,
      S_count = 1'b1
   } tos_state_e;

   typedef struct packed {
      logic [RES_CNT_W-1:0] count;
      logic                 timeout;
      logic                 overflow;
      logic [RES_PH_W-1:0]  phase;
   } tos_result_t;

endpackage : tos_dec_pkg

// File: rtl/tos_gap_detector.sv
// ---------------------------------------------------------------------------
// tos_gap_detector
// Rising-edge detector and low-run gap detector for the gated slow clock.
// Ports:
//   clk_tf         in  - single clock, rising edge
//   rst            in  - asynchronous active-high reset
//   stop_tos_count in  - gated slow clock, synchronous to clk_tf
//   run_clear      in  - restarts the low-run counter (top of second)
//   rise           out - stop_tos_count high while its registered copy is low
//   gap            out - low run has reached SlowClockPeriod cycles
// ---------------------------------------------------------------------------
module tos_gap_detector #(
   parameter int unsigned SlowClockPeriod = 32'd1920
) (
   input  logic clk_tf,
   input  logic rst,
   input  logic stop_tos_count,
   input  logic run_clear,
   output logic rise,
   output logic gap
);

   localparam int unsigned   RW      = $clog2(SlowClockPeriod + 32'd1);
   localparam logic [RW-1:0] RUN_MAX = RW'(SlowClockPeriod);

   logic          stc_q;
   logic          stc_d;
   logic [RW-1:0] run_q;
   logic [RW-1:0] run_d;

   // Next value of the edge register and the saturating low-run counter.
   always_comb begin
      stc_d = stop_tos_count;
      run_d = run_q;
      if (run_clear) begin
         run_d = '0;
      end else if (stop_tos_count) begin
         run_d = '0;
      end else if (run_q < RUN_MAX) begin
         run_d = run_q + RW'(1'b1);
      end else begin
         run_d = run_q;
      end
   end

   // Edge register resets high so a slow clock already high at reset
   // release is not mistaken for a rising edge.
   always_ff @(posedge clk_tf or posedge rst) begin
      if (rst) begin
         stc_q <= 1'b1;
         run_q <= '0;
      end else begin
         stc_q <= stc_d;
         run_q <= run_d;
      end
   end

   assign rise = stop_tos_count & ~stc_q;
   assign gap  = (run_q >= RUN_MAX);

endmodule : tos_gap_detector

// File: rtl/tos_count_decoder.sv
// ---------------------------------------------------------------------------
// tos_count_decoder
// Counts rising edges of the gated slow clock between a top-of-second mark
// and the next gap (or the next mark) and hands each window out through a
// valid/ready result register.
// Ports:
//   clk_tf          in  - single clock, rising edge
//   rst             in  - asynchronous active-high reset
//   tos_mark        in  - 1-cycle pulse, next edge is top of second
//   stop_tos_count  in  - gated slow clock
//   result_ready    in  - consumer accepts the held result
//   result_valid    out - result registers hold an unconsumed measurement
//   result_count    out - rising edges counted in the window (CW bits)
//   result_timeout  out - window closed by tos_mark rather than by a gap
//   result_overflow out - count saturated at MaxCount
//   result_overrun  out - sticky, a result was dropped while valid was high
//   result_phase    out - clk_tf cycles from tos_mark to last counted edge
// Optional feature: define TOS_DEC_PHASE_EN to build the phase counter;
// otherwise result_phase is constant zero.
// ---------------------------------------------------------------------------
module tos_count_decoder
   import tos_dec_pkg::*;
#(
   parameter  int unsigned ClocksPerSecond = 32'd19200000,
   parameter  int unsigned SlowClockPeriod = 32'd1920,
   localparam int unsigned MaxCount        = ClocksPerSecond / SlowClockPeriod,
   localparam int unsigned CW              = $clog2(MaxCount + 32'd1),
   localparam int unsigned PW              = $clog2(ClocksPerSecond)
) (
   input  logic          clk_tf,
   input  logic          rst,
   input  logic          tos_mark,
   input  logic          stop_tos_count,
   input  logic          result_ready,
   output logic          result_valid,
   output logic [CW-1:0] result_count,
   output logic          result_timeout,
   output logic          result_overflow,
   output logic          result_overrun,
   output logic [PW-1:0] result_phase
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MaxCount);

   tos_state_e    state_q;
   tos_state_e    state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          ovf_q;
   logic          ovf_d;
   tos_result_t   res_q;
   tos_result_t   res_d;
   logic          valid_q;
   logic          valid_d;
   logic          overrun_q;
   logic          overrun_d;

   logic          rise_s;
   logic          gap_s;
   logic          load_s;
   logic          ld_timeout_s;
   logic          count_edge_s;
   logic [PW-1:0] ld_phase_s;
   tos_result_t   ld_s;
   logic          unused_res_s;

   tos_gap_detector #(
      .SlowClockPeriod(SlowClockPeriod)
   ) u_gap (
      .clk_tf         (clk_tf),
      .rst            (rst),
      .stop_tos_count (stop_tos_count),
      .run_clear      (tos_mark),
      .rise           (rise_s),
      .gap            (gap_s)
   );

   // FSM state register.
   always_ff @(posedge clk_tf or posedge rst) begin
      if (rst) begin
         state_q <= S_idle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a mark always (re)opens a window, even on a gap cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_idle: begin
            if (tos_mark) state_d = S_count;
            else          state_d = S_idle;
         end
         S_count: begin
            if (tos_mark)   state_d = S_count;
            else if (gap_s) state_d = S_idle;
            else            state_d = S_count;
         end
         default: state_d = S_idle;
      endcase
   end

   // FSM outputs: when a window closes, and whether it was closed by a mark.
   always_comb begin
      load_s       = 1'b0;
      ld_timeout_s = 1'b0;
      case (state_q)
         S_idle: begin
            load_s       = 1'b0;
            ld_timeout_s = 1'b0;
         end
         S_count: begin
            load_s       = tos_mark | gap_s;
            ld_timeout_s = tos_mark & ~gap_s;
         end
         default: begin
            load_s       = 1'b0;
            ld_timeout_s = 1'b0;
         end
      endcase
   end

   // An edge coincident with the mark belongs to the new window.
   assign count_edge_s = rise_s & (tos_mark | ((state_q == S_count) & (cnt_q < MAX_CNT)));

   // Window edge counter with saturation and overflow flag.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (tos_mark) begin
         cnt_d = rise_s ? CW'(1'b1) : '0;
         ovf_d = 1'b0;
      end else if ((state_q == S_count) && rise_s) begin
         if (cnt_q < MAX_CNT) begin
            cnt_d = cnt_q + CW'(1'b1);
         end else begin
            cnt_d = cnt_q;
            ovf_d = 1'b1;
         end
      end else begin
         cnt_d = cnt_q;
         ovf_d = ovf_q;
      end
   end

   // Window counter registers.
   always_ff @(posedge clk_tf or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

`ifdef TOS_DEC_PHASE_EN
   logic [PW-1:0] ph_q;
   logic [PW-1:0] ph_d;
   logic [PW-1:0] wph_q;
   logic [PW-1:0] wph_d;

   // Cycles since the mark (saturating); latched on every counted edge.
   always_comb begin
      ph_d  = ph_q;
      wph_d = wph_q;
      if (tos_mark) begin
         ph_d = '0;
      end else if (ph_q != {PW{1'b1}}) begin
         ph_d = ph_q + PW'(1'b1);
      end else begin
         ph_d = ph_q;
      end
      if (tos_mark) begin
         wph_d = '0;
      end else if (count_edge_s) begin
         wph_d = ph_d;
      end else begin
         wph_d = wph_q;
      end
   end

   // Phase counter registers.
   always_ff @(posedge clk_tf or posedge rst) begin
      if (rst) begin
         ph_q  <= '0;
         wph_q <= '0;
      end else begin
         ph_q  <= ph_d;
         wph_q <= wph_d;
      end
   end

   assign ld_phase_s = wph_q;
`else
   assign ld_phase_s = '0;
`endif

   // Assemble the measurement that a closing window hands out.
   always_comb begin
      ld_s               = '0;
      ld_s.count[CW-1:0] = cnt_q;
      ld_s.timeout       = ld_timeout_s;
      ld_s.overflow      = ovf_q;
      ld_s.phase[PW-1:0] = ld_phase_s;
   end

   // Result hand-off: a load while a result is still unconsumed is dropped
   // and flagged; a load on the handshake cycle replaces the result.
   always_comb begin
      res_d     = res_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (load_s) begin
         if (valid_q && !result_ready) begin
            overrun_d = 1'b1;
         end else begin
            res_d   = ld_s;
            valid_d = 1'b1;
         end
      end else if (valid_q && result_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Result registers; overrun is cleared only by reset.
   always_ff @(posedge clk_tf or posedge rst) begin
      if (rst) begin
         res_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         res_q     <= res_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   // The wide result fields carry spare high bits that are always zero.
   assign unused_res_s = ^res_q;

   assign result_valid    = valid_q;
   assign result_count    = res_q.count[CW-1:0];
   assign result_timeout  = res_q.timeout;
   assign result_overflow = res_q.overflow;
   assign result_overrun  = overrun_q;
   assign result_phase    = res_q.phase[PW-1:0];

endmodule : tos_count_decoder

// File: tb/tb_tos_count_decoder.sv
// ---------------------------------------------------------------------------
// tb_tos_count_decoder
// Directed bench for tos_count_decoder with ClocksPerSecond=800,
// SlowClockPeriod=8 (MaxCount=100). Expected window results are queued as
// stimulus is driven and compared when the decoder hands a result over.
// Builds with or without TOS_DEC_PHASE_EN.
// ---------------------------------------------------------------------------
module tb_tos_count_decoder;

   localparam int unsigned CPS = 32'd800;
   localparam int unsigned SCP = 32'd8;
   localparam int unsigned CW  = $clog2(CPS / SCP + 32'd1);
   localparam int unsigned PW  = $clog2(CPS);

`ifdef TOS_DEC_PHASE_EN
   localparam bit PH_EN = 1'b1;
`else
   localparam bit PH_EN = 1'b0;
`endif

   typedef struct {
      int count;
      int timeout;
      int overflow;
      int phase;
   } exp_t;

   logic          clk_tf = 1'b0;
   logic          rst;
   logic          tos_mark;
   logic          stop_tos_count;
   logic          result_ready;
   logic          result_valid;
   logic [CW-1:0] result_count;
   logic          result_timeout;
   logic          result_overflow;
   logic          result_overrun;
   logic [PW-1:0] result_phase;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk_tf = ~clk_tf;

   tos_count_decoder #(
      .ClocksPerSecond(CPS),
      .SlowClockPeriod(SCP)
   ) dut (
      .clk_tf          (clk_tf),
      .rst             (rst),
      .tos_mark        (tos_mark),
      .stop_tos_count  (stop_tos_count),
      .result_ready    (result_ready),
      .result_valid    (result_valid),
      .result_count    (result_count),
      .result_timeout  (result_timeout),
      .result_overflow (result_overflow),
      .result_overrun  (result_overrun),
      .result_phase    (result_phase)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ph(input int v);
      return PH_EN ? v : 0;
   endfunction

   function automatic void expect_res(input int c, input int t, input int o, input int p);
      sb_q.push_back('{count: c, timeout: t, overflow: o, phase: p});
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_tf);
         #2;
      end
   endtask

   task automatic mark();
      tos_mark = 1'b1;
      tick(1);
      tos_mark = 1'b0;
   endtask

   task automatic pulses(input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) begin
         stop_tos_count = 1'b1;
         tick(hi);
         stop_tos_count = 1'b0;
         tick(lo);
      end
   endtask

   task automatic wait_valid(input string tag, input int max, output int n);
      n = 0;
      while (result_valid !== 1'b1 && n < max) begin
         tick(1);
         n++;
      end
      check(tag, 32'(result_valid), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},    32'(result_valid),    32'd0);
      check({tag, "_count"},    32'(result_count),    32'd0);
      check({tag, "_timeout"},  32'(result_timeout),  32'd0);
      check({tag, "_overflow"}, 32'(result_overflow), 32'd0);
      check({tag, "_overrun"},  32'(result_overrun),  32'd0);
      check({tag, "_phase"},    32'(result_phase),    32'd0);
   endtask

   // Scoreboard side: compare every result at the point it is handed over.
   always @(negedge clk_tf) begin
      if (rst === 1'b0 && result_valid === 1'b1 && result_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_result", 32'(sb_q.size()), 32'd1);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_count",    32'(result_count),    32'(mon_e.count));
            check("sb_timeout",  32'(result_timeout),  32'(mon_e.timeout));
            check("sb_overflow", 32'(result_overflow), 32'(mon_e.overflow));
            check("sb_phase",    32'(result_phase),    32'(mon_e.phase));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst            = 1'b1;
      tos_mark       = 1'b0;
      stop_tos_count = 1'b0;
      result_ready   = 1'b1;
      tick(3);
      check_all_zero("reset");
      rst = 1'b0;
      tick(4);
      check("idle_no_valid", 32'(result_valid), 32'd0);

      // 37 pulses then low: gap closes the window 9 cycles after the fall.
      mark();
      expect_res(37, 0, 0, ph(289));
      pulses(36, 4, 4);
      stop_tos_count = 1'b1;
      tick(4);
      stop_tos_count = 1'b0;
      wait_valid("gap37_valid", 20, n);
      check("gap37_latency", 32'(n), 32'd9);
      tick(3);

      // Mark then constant low: empty window after 8 low cycles.
      mark();
      expect_res(0, 0, 0, 0);
      wait_valid("empty_valid", 20, n);
      check("empty_latency", 32'(n), 32'd9);
      tick(3);

      // 100 pulses closed by the next mark, then an empty window.
      mark();
      pulses(100, 4, 4);
      expect_res(100, 1, 0, ph(793));
      mark();
      check("mark_close_valid", 32'(result_valid), 32'd1);
      expect_res(0, 0, 0, 0);
      tick(2);
      wait_valid("after_mark_valid", 20, n);
      tick(3);

      // Gap and mark on the same cycle: gap result, new window opens.
      mark();
      pulses(2, 4, 4);
      tick(int'(SCP) - 4);
      expect_res(2, 0, 0, ph(9));
      mark();
      check("sim_gap_valid", 32'(result_valid), 32'd1);
      expect_res(0, 0, 0, 0);
      tick(2);
      wait_valid("sim_second_valid", 20, n);
      tick(3);

      // 120 fast pulses: count saturates at MaxCount.
      mark();
      pulses(120, 3, 3);
      expect_res(100, 0, 1, ph(595));
      wait_valid("ovf_valid", 20, n);
      tick(3);

      // Consumer stalled across two windows: first held, overrun flagged.
      result_ready = 1'b0;
      mark();
      pulses(5, 4, 4);
      wait_valid("ovr_first_valid", 20, n);
      tick(2);
      mark();
      pulses(3, 4, 4);
      tick(12);
      check("ovr_hold_valid", 32'(result_valid), 32'd1);
      check("ovr_hold_count", 32'(result_count), 32'd5);
      check("ovr_flag", 32'(result_overrun), 32'd1);
      expect_res(5, 0, 0, ph(33));
      result_ready = 1'b1;
      tick(2);
      check("ovr_drained", 32'(result_valid), 32'd0);
      check("ovr_sticky", 32'(result_overrun), 32'd1);

      // Reset mid-window: everything cleared, partial window discarded.
      mark();
      pulses(20, 4, 4);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      tick(1);
      rst = 1'b0;
      tick(15);
      check("midrst_no_result", 32'(result_valid), 32'd0);
      mark();
      pulses(6, 4, 4);
      expect_res(6, 0, 0, ph(41));
      wait_valid("fresh_valid", 20, n);
      tick(3);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_tos_count_decoder

// File: doc/tos_count_decoder.md
TOS_COUNT_DECODER -- requirements
Module: tos_count_decoder

Interface
REQ-001 SHALL have parameter ClocksPerSecond, default 19200000, clk_tf cycles per second.
REQ-002 SHALL have parameter SlowClockPeriod, default 1920, clk_tf cycles per stop_tos_count period (10 kHz).
REQ-003 SHALL derive localparam MaxCount = ClocksPerSecond/SlowClockPeriod; CW = $clog2(MaxCount+1); PW = $clog2(ClocksPerSecond).
REQ-004 SHALL have port clk_tf, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port tos_mark, input, 1, 1-cycle pulse; next clk_tf edge is top of second.
REQ-007 SHALL have port stop_tos_count, input, 1, gated slow clock; synchronous to clk_tf, held low once gated off.
REQ-008 SHALL have port result_ready, input, 1, consumer accepts result.
REQ-009 SHALL have port result_valid, output, 1, result registers hold an unconsumed measurement.
REQ-010 SHALL have port result_count, output, CW, rising edges counted in the window.
REQ-011 SHALL have port result_timeout, output, 1, window closed by tos_mark, not by a gap.
REQ-012 SHALL have port result_overflow, output, 1, count saturated at MaxCount.
REQ-013 SHALL have port result_overrun, output, 1, sticky; a result was dropped while result_valid was high.
REQ-014 SHALL have port result_phase, output, PW, clk_tf cycles from tos_mark to the last counted edge.

Function
REQ-015 SHALL detect a rising edge as stop_tos_count==1 with its registered copy ==0.
REQ-016 SHALL use FSM S_idle, S_count; S_idle->S_count on tos_mark; S_count->S_idle on gap detect.
REQ-017 SHALL clear the edge counter on entry to S_count; edges sampled from the cycle after tos_mark count.
REQ-018 SHALL count low-run cycles of stop_tos_count; run >= SlowClockPeriod in S_count is a gap detect.
REQ-019 SHALL on gap detect load result regs with timeout=0 and assert result_valid the following cycle.
REQ-020 SHALL on tos_mark in S_count load result regs with timeout=1, clear counter, stay S_count.
REQ-021 SHALL on simultaneous gap detect and tos_mark load timeout=0 and enter S_count.
REQ-022 SHALL count a rising edge coincident with tos_mark in the new window.
REQ-023 SHALL saturate the counter at MaxCount and set overflow for that window.
REQ-024 SHALL deassert result_valid the cycle after result_valid && result_ready.
REQ-025 SHALL, if a load occurs while result_valid && !result_ready, keep old result, set result_overrun.
REQ-026 SHALL accept a load on the same cycle as a handshake; result_valid stays 1 with new data.
REQ-027 SHALL clear result_overrun only on reset.

Reset
REQ-028 SHALL on rst asynchronously drive every output and counter to 0 and the FSM to S_idle.
REQ-029 SHALL discard any partial window when rst asserts mid-count; no result emitted.
REQ-030 SHALL reset the stop_tos_count edge register to 1, so no edge is seen on the first cycle.

Configuration
REQ-031 SHALL, with TOS_DEC_PHASE_EN defined, run a PW-bit cycle counter from tos_mark and latch it on each counted edge into result_phase.
REQ-032 SHALL, without TOS_DEC_PHASE_EN, omit that counter and tie result_phase to 0.

Structure
REQ-033 SHALL place the state enum and a result struct (count, timeout, overflow, phase) in package tos_dec_pkg.
REQ-034 SHALL implement edge detect and low-run gap detect in sub-module tos_gap_detector.

Verification (SlowClockPeriod=8, ClocksPerSecond=800, MaxCount=100)
REQ-035 SHALL check that tos_mark then 37 pulses (4 high/4 low) then low gives result_count=37, timeout=0, result_valid 9 cycles after the last fall.
REQ-036 SHALL check that tos_mark, 100 continuous pulses, then tos_mark gives count=100, timeout=1 on the second mark; with PHASE_EN, phase=793.
REQ-037 SHALL check that result_ready=0 with two windows completed gives the first result held and result_overrun=1.
REQ-038 SHALL check that rst pulsed after 20 pulses gives all outputs 0, no result, and a fresh next window counting from 0.
REQ-039 SHALL check that tos_mark then constant low gives count=0, timeout=0 after 8 low cycles.
REQ-040 SHALL check that 120 pulses at period 6 before a gap give count=100, overflow=1.
